// File: rtl/tla_pkg.sv
// Shared types, default widths and helpers for the capture window engine.
package tla_pkg;

  localparam int unsigned CH_NUM_DEF = 2;
  localparam int unsigned ADC_W_DEF  = 14;
  localparam int unsigned LEN_W_DEF  = 32;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StArmed   = 2'd1,
    StCapture = 2'd2,
    StDrain   = 2'd3
  } tla_state_e;

  // Increment v, holding at the all-ones value of a width-bit field.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned width);
    logic [31:0] max_v;
    max_v = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/tla_fifo_fwft.sv
// First-word-fall-through FIFO: head entry is visible on rd_data_o while not empty.
module tla_fifo_fwft #(
  parameter int unsigned Width = 30,
  parameter int unsigned AddrW = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [Width-1:0] rd_data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned Depth = 1 << AddrW;

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW:0]   wptr_q, rptr_q;
  logic             do_wr, do_rd;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                   (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
  assign do_rd   = rd_en_i & ~empty_o;
  // A read in the same cycle frees a slot, so a write into a full FIFO still lands.
  assign do_wr   = wr_en_i & (~full_o | do_rd);

  // Pointers; the extra MSB tells full from empty.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_wr) wptr_q <= wptr_q + (AddrW + 1)'(1);
      if (do_rd) rptr_q <= rptr_q + (AddrW + 1)'(1);
    end
  end

  // Storage array; contents are don't-care once pointers are reset.
  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wptr_q[AddrW-1:0]] <= wr_data_i;
  end

  assign rd_data_o = empty_o ? '0 : mem_q[rptr_q[AddrW-1:0]];

endmodule

// File: rtl/tla_cap_window.sv
// Triggered, decimating multi-channel ADC capture with FWFT output buffer.
module tla_cap_window
  import tla_pkg::*;
#(
  parameter int unsigned CH_NUM  = CH_NUM_DEF,
  parameter int unsigned ADC_W   = ADC_W_DEF,
  parameter int unsigned LEN_W   = LEN_W_DEF,
  parameter int unsigned WD_W    = 3,
  parameter int unsigned FIFO_AW = 4,
  parameter int unsigned DROP_W  = 16
) (
  input  logic                     Gc_clk125,
  input  logic                     Gc_rst,
  input  logic                     Gc_cap_en,
  input  logic                     Gc_cap_mode,
  input  logic [WD_W-1:0]          Gc_cap_wdis,
  input  logic [LEN_W-1:0]         Gc_cap_plus,
  input  logic                     Gc_cap_trig,
  input  logic                     Gc_adc_vld,
  input  logic [CH_NUM*ADC_W-1:0]  Gc_adc_data,
  input  logic [CH_NUM-1:0]        Gc_adc_of,
  output logic                     Gc_capr_rdy,
  output logic                     Gc_cap_busy,
  output logic                     Gc_cap_cmpt,
  output logic [CH_NUM*ADC_W-1:0]  Gc_out_data,
  output logic                     Gc_out_of,
  output logic                     Gc_out_last,
  output logic                     Gc_out_vld,
  input  logic                     Gc_out_rdy,
  output logic [DROP_W-1:0]        Gc_drop_cnt,
  output logic                     Gc_of_sticky
);

  localparam int unsigned DataW = CH_NUM * ADC_W;
  localparam int unsigned FifoW = DataW + 2;
  // Wide enough to count up to 2^(2^WD_W - 1) - 1.
  localparam int unsigned DecW  = (1 << WD_W) - 1;

  tla_state_e        state_q, state_d;
  logic              trig_q;
  logic [WD_W-1:0]   wdis_q, wdis_d;
  logic [LEN_W-1:0]  len_m1_q, len_m1_d;
  logic [LEN_W-1:0]  smp_cnt_q, smp_cnt_d;
  logic [DecW-1:0]   dec_cnt_q, dec_cnt_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  logic              of_sticky_q, of_sticky_d;
  logic              capr_rdy_q;
  logic              cmpt_q, cmpt_d;

  logic              trig_edge, rd_hs, sel, wr, drop, is_last;
  logic [DecW-1:0]   dec_max;
  logic              fifo_empty, fifo_full;
  logic [FifoW-1:0]  fifo_wdata, fifo_rdata;

  assign trig_edge  = Gc_cap_trig & ~trig_q;
  assign Gc_out_vld = ~fifo_empty;
  assign rd_hs      = Gc_out_vld & Gc_out_rdy;
  assign dec_max    = ~({DecW{1'b1}} << wdis_q);
  assign sel        = (state_q == StCapture) & Gc_adc_vld & (dec_cnt_q == '0);
  assign wr         = sel & (~fifo_full | rd_hs);
  assign drop       = sel & ~wr;
  assign is_last    = (smp_cnt_q == len_m1_q);
  assign fifo_wdata = {is_last, |Gc_adc_of, Gc_adc_data};

  tla_fifo_fwft #(
    .Width (FifoW),
    .AddrW (FIFO_AW)
  ) u_fifo (
    .clk_i     (Gc_clk125),
    .rst_ni    (Gc_rst),
    .wr_en_i   (wr),
    .wr_data_i (fifo_wdata),
    .rd_en_i   (Gc_out_rdy),
    .rd_data_o (fifo_rdata),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full)
  );

  assign {Gc_out_last, Gc_out_of, Gc_out_data} = fifo_rdata;

  // Next-state logic for the capture FSM, counters and sticky flags.
  always_comb begin
    state_d     = state_q;
    wdis_d      = wdis_q;
    len_m1_d    = len_m1_q;
    smp_cnt_d   = smp_cnt_q;
    dec_cnt_d   = dec_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    of_sticky_d = of_sticky_q;
    cmpt_d      = 1'b0;

    if (drop) drop_cnt_d = DROP_W'(sat_inc(32'(drop_cnt_q), DROP_W));

    unique case (state_q)
      StIdle: begin
        if (Gc_cap_en) state_d = StArmed;
      end
      StArmed: begin
        if (!Gc_cap_en) begin
          state_d = StIdle;
        end else if (trig_edge) begin
          state_d     = StCapture;
          wdis_d      = Gc_cap_wdis;
          // Zero length behaves as a single-sample capture.
          len_m1_d    = (Gc_cap_plus == '0) ? '0 : Gc_cap_plus - LEN_W'(1);
          smp_cnt_d   = '0;
          dec_cnt_d   = '0;
          of_sticky_d = 1'b0;
        end
      end
      StCapture: begin
        if (Gc_adc_vld) dec_cnt_d = (dec_cnt_q == dec_max) ? '0 : dec_cnt_q + DecW'(1);
        if (wr) begin
          smp_cnt_d = smp_cnt_q + LEN_W'(1);
          if (|Gc_adc_of) of_sticky_d = 1'b1;
          if (is_last) state_d = StDrain;
        end
      end
      StDrain: begin
        if (rd_hs && Gc_out_last) begin
          cmpt_d  = 1'b1;
          state_d = (Gc_cap_mode && Gc_cap_en) ? StArmed : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge Gc_clk125) begin
    if (!Gc_rst) begin
      state_q     <= StIdle;
      trig_q      <= 1'b0;
      wdis_q      <= '0;
      len_m1_q    <= '0;
      smp_cnt_q   <= '0;
      dec_cnt_q   <= '0;
      drop_cnt_q  <= '0;
      of_sticky_q <= 1'b0;
      capr_rdy_q  <= 1'b0;
      cmpt_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      trig_q      <= Gc_cap_trig;
      wdis_q      <= wdis_d;
      len_m1_q    <= len_m1_d;
      smp_cnt_q   <= smp_cnt_d;
      dec_cnt_q   <= dec_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      of_sticky_q <= of_sticky_d;
      capr_rdy_q  <= (state_q == StArmed);
      cmpt_q      <= cmpt_d;
    end
  end

  assign Gc_capr_rdy  = capr_rdy_q;
  assign Gc_cap_busy  = (state_q == StCapture) || (state_q == StDrain);
  assign Gc_cap_cmpt  = cmpt_q;
  assign Gc_drop_cnt  = drop_cnt_q;
  assign Gc_of_sticky = of_sticky_q;

endmodule

// File: tb/tb_tla_cap_window.sv
// Scoreboard bench for tla_cap_window with a cycle-level behavioural model.
module tb_tla_cap_window;

  localparam int unsigned CH_NUM  = 2;
  localparam int unsigned ADC_W   = 14;
  localparam int unsigned LEN_W   = 32;
  localparam int unsigned WD_W    = 3;
  localparam int unsigned FIFO_AW = 4;
  localparam int unsigned DROP_W  = 16;
  localparam int unsigned DW      = CH_NUM * ADC_W;
  localparam int          DEPTH   = 1 << FIFO_AW;
  localparam int          DROP_MAX = (1 << DROP_W) - 1;

  logic              clk = 1'b0;
  logic              Gc_rst, Gc_cap_en, Gc_cap_mode, Gc_cap_trig, Gc_adc_vld, Gc_out_rdy;
  logic [WD_W-1:0]   Gc_cap_wdis;
  logic [LEN_W-1:0]  Gc_cap_plus;
  logic [DW-1:0]     Gc_adc_data;
  logic [CH_NUM-1:0] Gc_adc_of;
  logic              Gc_capr_rdy, Gc_cap_busy, Gc_cap_cmpt, Gc_out_of, Gc_out_last, Gc_out_vld;
  logic              Gc_of_sticky;
  logic [DW-1:0]     Gc_out_data;
  logic [DROP_W-1:0] Gc_drop_cnt;

  always #4 clk = ~clk;

  tla_cap_window #(
    .CH_NUM (CH_NUM), .ADC_W (ADC_W), .LEN_W (LEN_W),
    .WD_W (WD_W), .FIFO_AW (FIFO_AW), .DROP_W (DROP_W)
  ) dut (
    .Gc_clk125    (clk),
    .Gc_rst       (Gc_rst),
    .Gc_cap_en    (Gc_cap_en),
    .Gc_cap_mode  (Gc_cap_mode),
    .Gc_cap_wdis  (Gc_cap_wdis),
    .Gc_cap_plus  (Gc_cap_plus),
    .Gc_cap_trig  (Gc_cap_trig),
    .Gc_adc_vld   (Gc_adc_vld),
    .Gc_adc_data  (Gc_adc_data),
    .Gc_adc_of    (Gc_adc_of),
    .Gc_capr_rdy  (Gc_capr_rdy),
    .Gc_cap_busy  (Gc_cap_busy),
    .Gc_cap_cmpt  (Gc_cap_cmpt),
    .Gc_out_data  (Gc_out_data),
    .Gc_out_of    (Gc_out_of),
    .Gc_out_last  (Gc_out_last),
    .Gc_out_vld   (Gc_out_vld),
    .Gc_out_rdy   (Gc_out_rdy),
    .Gc_drop_cnt  (Gc_drop_cnt),
    .Gc_of_sticky (Gc_of_sticky)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          of;
    logic          last;
  } beat_t;

  beat_t sb[$];
  beat_t got[$];
  int n_chk = 0, n_pass = 0;
  int n_beats = 0, n_cmpt = 0;
  bit model_on = 1'b0;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endfunction

  // ---------------- reference model ----------------
  typedef enum int {MIdle, MArmed, MCap, MDrain} mphase_e;
  mphase_e m_phase = MIdle;
  int      m_occ = 0, m_vcnt = 0, m_written = 0, m_drop = 0, m_period = 1;
  longint  m_len = 1;
  bit      m_trig_q = 0, m_capr = 0, m_cmpt = 0, m_sticky = 0;
  bit      m_rd, m_wr;

  // Checks the current cycle's outputs, then predicts the effect of the coming edge.
  always @(negedge clk) begin
    if (model_on) begin
      check("capr_rdy", Gc_capr_rdy, m_capr);
      check("cap_busy", Gc_cap_busy, (m_phase == MCap) || (m_phase == MDrain));
      check("cap_cmpt", Gc_cap_cmpt, m_cmpt);
      check("out_vld", Gc_out_vld, m_occ > 0);
      check("drop_cnt", Gc_drop_cnt, m_drop);
      check("of_sticky", Gc_of_sticky, m_sticky);
      if (!Gc_rst) begin
        m_phase = MIdle; m_occ = 0; m_drop = 0; m_sticky = 0;
        m_trig_q = 0; m_capr = 0; m_cmpt = 0;
        sb.delete();
      end else begin
        m_capr = (m_phase == MArmed);
        m_cmpt = 0;
        m_rd   = (m_occ > 0) && Gc_out_rdy;
        m_wr   = 0;
        case (m_phase)
          MIdle: if (Gc_cap_en) m_phase = MArmed;
          MArmed: begin
            if (!Gc_cap_en) m_phase = MIdle;
            else if (Gc_cap_trig && !m_trig_q) begin
              m_phase   = MCap;
              m_period  = 1 << Gc_cap_wdis;
              m_len     = (Gc_cap_plus == 0) ? 1 : longint'(Gc_cap_plus);
              m_vcnt    = 0;
              m_written = 0;
              m_sticky  = 0;
            end
          end
          MCap: begin
            if (Gc_adc_vld) begin
              if (m_vcnt % m_period == 0) begin
                if (m_occ < DEPTH || m_rd) begin
                  m_wr = 1;
                  sb.push_back({Gc_adc_data, |Gc_adc_of, longint'(m_written) == m_len - 1});
                  if (|Gc_adc_of) m_sticky = 1;
                  m_written++;
                  if (longint'(m_written) == m_len) m_phase = MDrain;
                end else if (m_drop != DROP_MAX) begin
                  m_drop++;
                end
              end
              m_vcnt++;
            end
          end
          MDrain: begin
            if (m_rd && m_occ == 1) begin
              m_cmpt  = 1;
              m_phase = (Gc_cap_mode && Gc_cap_en) ? MArmed : MIdle;
            end
          end
          default: m_phase = MIdle;
        endcase
        m_occ    = m_occ + int'(m_wr) - int'(m_rd);
        m_trig_q = Gc_cap_trig;
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (model_on) begin
      if (Gc_cap_cmpt) n_cmpt++;
      if (Gc_rst && Gc_out_vld && Gc_out_rdy) begin
        n_beats++;
        got.push_back({Gc_out_data, Gc_out_of, Gc_out_last});
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL beat_unexpected: got data %0h with no expected beat at %0t",
                   Gc_out_data, $time);
        end else begin
          beat_t e;
          e = sb.pop_front();
          check("out_data", Gc_out_data, e.data);
          check("out_of", Gc_out_of, e.of);
          check("out_last", Gc_out_last, e.last);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  int vld_pct = 100, rdy_pct = 100, of_pct = 0, of_at = -1, vs_idx = 0;
  bit inc_data = 0;
  logic [DW-1:0] inc_val = '0;

  // Drive this cycle's inputs, then advance to just after the next rising edge.
  task automatic tick(input bit t);
    Gc_cap_trig = t;
    Gc_adc_vld  = ($urandom_range(99) < vld_pct);
    Gc_adc_data = inc_data ? inc_val : DW'({$urandom(), $urandom()});
    Gc_adc_of   = '0;
    if (Gc_adc_vld && !t) begin
      if (vs_idx == of_at) Gc_adc_of = CH_NUM'(2);
      else if ($urandom_range(99) < of_pct) Gc_adc_of = CH_NUM'($urandom());
      vs_idx++;
      if (inc_data) inc_val++;
    end
    if (t) begin
      vs_idx  = 0;
      inc_val = '0;
    end
    Gc_out_rdy = ($urandom_range(99) < rdy_pct);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_armed(input string name);
    int n;
    n = 0;
    while (Gc_capr_rdy !== 1'b1 && n < 50) begin
      tick(0);
      n++;
    end
    n_chk++;
    if (n < 50) n_pass++;
    else $display("FAIL %s_armed: capr_rdy got 0 required 1 within 50 cycles", name);
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (Gc_cap_cmpt !== 1'b1 && n < budget) begin
      tick(0);
      n++;
    end
    n_chk++;
    if (n < budget) n_pass++;
    else $display("FAIL %s_done: cap_cmpt got 0 required 1 within %0d cycles", name, budget);
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) tick(0);
  endtask

  initial begin
    int b0, c0, viol;
    logic [DROP_W-1:0] d0;
    Gc_rst = 0; Gc_cap_en = 0; Gc_cap_mode = 0; Gc_cap_wdis = '0; Gc_cap_plus = '0;
    Gc_cap_trig = 0; Gc_adc_vld = 0; Gc_adc_data = '0; Gc_adc_of = '0; Gc_out_rdy = 0;
    tick(0);
    model_on = 1;
    tick(0);
    tick(0);
    check("rst_out_vld", Gc_out_vld, 0);
    check("rst_out_data", Gc_out_data, 0);
    check("rst_out_last", Gc_out_last, 0);
    check("rst_drop_cnt", Gc_drop_cnt, 0);
    check("rst_capr_rdy", Gc_capr_rdy, 0);
    Gc_rst = 1;

    // Single shot, no decimation, length 8.
    Gc_cap_mode = 0; Gc_cap_wdis = 0; Gc_cap_plus = 8; Gc_cap_en = 1;
    wait_armed("t1");
    got.delete(); b0 = n_beats; c0 = n_cmpt;
    tick(1);
    wait_done("t1", 100);
    Gc_cap_en = 0;
    idle_ticks(4);
    check("t1_beats", got.size(), 8);
    check("t1_cmpt", n_cmpt - c0, 1);
    check("t1_capr_after", Gc_capr_rdy, 0);
    if (got.size() == 8) begin
      check("t1_beat8_last", got[7].last, 1);
      check("t1_beat7_last", got[6].last, 0);
    end

    // Decimation by 4 on a counting ramp.
    Gc_cap_wdis = 2; Gc_cap_plus = 4; inc_data = 1; Gc_cap_en = 1;
    wait_armed("t2");
    got.delete();
    tick(1);
    wait_done("t2", 100);
    Gc_cap_en = 0;
    idle_ticks(4);
    check("t2_beats", got.size(), 4);
    for (int i = 0; i < got.size() && i < 4; i++) check("t2_dec_value", got[i].data, i * 4);

    // Backpressure: 30 cycles with the sink stalled.
    Gc_cap_wdis = 0; Gc_cap_plus = 40; Gc_cap_en = 1;
    wait_armed("t3");
    got.delete(); b0 = n_beats; d0 = Gc_drop_cnt; rdy_pct = 0;
    tick(1);
    idle_ticks(29);
    check("t3_no_beats_while_stalled", n_beats - b0, 0);
    check("t3_drop_while_full", int'(Gc_drop_cnt) - int'(d0), 13);
    rdy_pct = 100;
    wait_done("t3", 300);
    Gc_cap_en = 0;
    idle_ticks(4);
    check("t3_beats", got.size(), 40);
    viol = 0;
    for (int i = 1; i < got.size(); i++) if (got[i].data <= got[i-1].data) viol++;
    check("t3_no_duplicates", viol, 0);
    inc_data = 0;

    // Continuous mode: trigger during capture ignored, re-trigger in first armed cycle.
    Gc_cap_mode = 1; Gc_cap_plus = 3; Gc_cap_en = 1;
    wait_armed("t4");
    b0 = n_beats; c0 = n_cmpt;
    tick(1); tick(0); tick(1); tick(0);
    wait_done("t4a", 100);
    tick(1);
    wait_done("t4b", 100);
    Gc_cap_en = 0; Gc_cap_mode = 0;
    idle_ticks(4);
    check("t4_beats", n_beats - b0, 6);
    check("t4_cmpt", n_cmpt - c0, 2);

    // Overflow flag on the second written sample.
    Gc_cap_plus = 4; of_at = 1; Gc_cap_en = 1;
    wait_armed("t5");
    got.delete();
    tick(1);
    wait_done("t5", 100);
    of_at = -1;
    check("t5_sticky_set", Gc_of_sticky, 1);
    if (got.size() == 4) begin
      check("t5_beat1_of", got[0].of, 0);
      check("t5_beat2_of", got[1].of, 1);
      check("t5_beat3_of", got[2].of, 0);
    end
    Gc_cap_en = 0;
    idle_ticks(3);
    Gc_cap_en = 1;
    wait_armed("t5b");
    tick(1);
    check("t5_sticky_cleared", Gc_of_sticky, 0);
    wait_done("t5b", 100);
    Gc_cap_en = 0;
    idle_ticks(4);

    // Reset in the middle of a capture.
    Gc_cap_plus = 20; Gc_cap_en = 1;
    wait_armed("t6");
    c0 = n_cmpt;
    tick(1);
    idle_ticks(5);
    check("t6_busy_before", Gc_cap_busy, 1);
    Gc_rst = 0;
    tick(0);
    Gc_rst = 1;
    check("t6_vld_after_rst", Gc_out_vld, 0);
    check("t6_busy_after_rst", Gc_cap_busy, 0);
    check("t6_data_after_rst", Gc_out_data, 0);
    tick(0);
    tick(0);
    check("t6_armed_after_rst", Gc_capr_rdy, 1);
    Gc_cap_en = 0;
    idle_ticks(4);
    check("t6_no_cmpt", n_cmpt - c0, 0);

    // Randomised captures.
    of_pct = 15;
    for (int it = 0; it < 25; it++) begin
      Gc_cap_mode = 1'($urandom_range(1));
      Gc_cap_wdis = WD_W'($urandom_range(3));
      Gc_cap_plus = LEN_W'($urandom_range(20));
      vld_pct = $urandom_range(40, 100);
      rdy_pct = $urandom_range(20, 100);
      Gc_cap_en = 1;
      wait_armed("rand");
      tick(1);
      wait_done("rand", 3000);
      if ($urandom_range(1) == 0) begin
        Gc_cap_en = 0;
        idle_ticks(2);
      end
    end

    rdy_pct = 100; vld_pct = 100; of_pct = 0; Gc_cap_en = 0;
    idle_ticks(30);
    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tla_cap_window.md
# tla_cap_window

Single-clock, parametrised multi-channel ADC capture engine in the Gc_clk125 domain, downstream of the ADC clock-domain crossing. It arms on request, starts on a trigger edge, and decimates the incoming sample vector by 2^wdis. It buffers exactly the configured number of samples in a first-word-fall-through (FWFT) FIFO and streams them out with valid/ready and a last flag. It replaces the fixed single-channel capture path with channel-count, length, decimation and continuous re-arm support, plus drop and overflow accounting.

## Interface
Parameters:
- CH_NUM, 2, number of ADC channels packed in one sample vector
- ADC_W, 14, bits per channel sample
- LEN_W, 32, width of capture length
- WD_W, 3, width of decimation exponent
- FIFO_AW, 4, FIFO address width (depth 2^FIFO_AW)
- DROP_W, 16, width of drop counter

Ports:
- Gc_clk125 in 1: the only clock
- Gc_rst in 1: reset, synchronous, active-low
- Gc_cap_en in 1: arm request (level)
- Gc_cap_mode in 1: 0 = single, 1 = continuous re-arm
- Gc_cap_wdis in WD_W: decimation exponent; keep every 2^wdis-th valid sample
- Gc_cap_plus in LEN_W: samples per capture; 0 is treated as 1
- Gc_cap_trig in 1: trigger; rising edge is used
- Gc_adc_vld in 1: input sample valid
- Gc_adc_data in CH_NUM*ADC_W: channel 0 in the LSBs
- Gc_adc_of in CH_NUM: per-channel overflow for the current sample
- Gc_capr_rdy out 1: armed, waiting for trigger
- Gc_cap_busy out 1: in CAPTURE or DRAIN
- Gc_cap_cmpt out 1: one-cycle pulse at capture completion
- Gc_out_data out CH_NUM*ADC_W: buffered sample
- Gc_out_of out 1: OR of Gc_adc_of for that sample
- Gc_out_last out 1: final sample of the capture
- Gc_out_vld out 1 / Gc_out_rdy in 1: output handshake
- Gc_drop_cnt out DROP_W: selected samples lost because the FIFO was full; saturating
- Gc_of_sticky out 1: any captured sample had overflow; cleared on trigger acceptance

## Operation
States: IDLE, ARMED, CAPTURE, DRAIN.
- IDLE -> ARMED when Gc_cap_en=1.
- ARMED:
  - Gc_cap_en=0 -> IDLE.
  - Trigger rising edge (trig & ~trig_q) -> CAPTURE.
  - On this transition: latch wdis and length, clear the decimation counter, sample counter and Gc_of_sticky.
  - Gc_drop_cnt is not cleared.
- CAPTURE:
  - Selection: a sample is selected when Gc_adc_vld=1 and dec_cnt==0. dec_cnt increments on each valid sample and wraps at 2^wdis-1; wdis=0 selects every valid sample.
  - Write: a selected sample is written when the FIFO is not full, and the sample counter increments.
  - Drop: a selected sample with the FIFO full is dropped and Gc_drop_cnt increments (saturating at all-ones). Dropped samples do not count toward length.
  - The write with counter == length-1 carries last=1, then -> DRAIN.
- DRAIN:
  - On the output handshake of the last-tagged beat, pulse Gc_cap_cmpt.
  - Then -> ARMED if Gc_cap_mode=1 and Gc_cap_en=1, else -> IDLE.
- Gc_cap_en is ignored in CAPTURE/DRAIN; a started capture always completes.
- Triggers in IDLE, CAPTURE and DRAIN are ignored. The edge detector register updates in every state.
- Gc_out_of stores the OR of Gc_adc_of with the sample. Gc_of_sticky sets on any written sample with of=1.

## Timing
- Reset: state=IDLE, FIFO empty. All outputs 0, including Gc_drop_cnt and trig_q.
- Reset mid-operation flushes the FIFO. No Gc_cap_cmpt is issued.
- Gc_capr_rdy=1 in the cycle after the state becomes ARMED (registered output).
- Trigger edge in cycle T -> state=CAPTURE at T+1. A sample is first eligible in cycle T+1.
- Sample written at cycle N -> Gc_out_vld=1 at N+1 (FWFT, one-cycle latency).
- A simultaneous FIFO read and write when full is allowed: the write succeeds.
- Gc_out_data, Gc_out_of and Gc_out_last are held stable while Gc_out_vld=1 and Gc_out_rdy=0.
- Gc_cap_cmpt is asserted in the cycle after the final handshake. The next state takes effect in the same cycle.
- In continuous mode, a trigger edge in the first ARMED cycle after DRAIN is accepted.
- Length wrap: a counter of width LEN_W is compared to length-1. Length 0 maps to 1. Length 2^LEN_W-1 is legal.

## Structure
- Shared package tla_pkg:
  - state encoding constants
  - default widths CH_NUM, ADC_W, LEN_W
  - saturating-increment function
- Sub-module tla_fifo_fwft:
  - width CH_NUM*ADC_W+2 (data, of, last), depth 2^FIFO_AW
  - full/empty flags, one extra pointer bit
- Top contains the FSM, edge detector, decimator, counters and sticky flags.

## Test plan
- Single, wdis=0, length=8, continuous valid input, out_rdy=1 -> 8 beats, last on beat 8, cmpt one cycle after beat 8, return to IDLE; capr_rdy=0 afterwards.
- Decimation, wdis=2, length=4, data = incrementing counter 0..N -> output values 0,4,8,12.
- Backpressure: FIFO_AW=4, length=40, out_rdy=0 for 30 cycles:
  - exactly 16 beats stored
  - drop_cnt = number of selected samples while full
  - 40 beats eventually delivered with no duplicates
- Continuous mode, cap_en held high, two trigger edges with length=3 -> two cmpt pulses, 6 beats total. A trigger during CAPTURE is ignored.
- Overflow: of[1]=1 on the 2nd written sample -> out_of=1 on beat 2 only, of_sticky=1; a new trigger clears of_sticky.
- Reset asserted mid-CAPTURE -> outputs 0, FIFO empty, no cmpt; after release with cap_en=1, ARMED within 2 cycles.
